// File: rtl/rob_buffer_pkg.sv
// rtl/rob_buffer_pkg.sv - shared widths, tag codes and ROB entry layout
package rob_buffer_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int PTR_W     = 4;
    localparam int IDX_W     = 6;
    localparam int DATA_W    = 32;
    localparam int REG_W     = 5;
    localparam int CNT_W     = 5;

    // Tag value meaning "no producer / operand already available"
    localparam logic [IDX_W-1:0] INVALID_NUM = 6'b010000;

    typedef enum logic [3:0] {
        ADD_OP,
        SUB_OP,
        AND_OP,
        OR_OP,
        XOR_OP,
        SLL_OP,
        SRL_OP,
        MUL_OP,
        LW_OP,
        SW_OP,
        BEQ_OP,
        LI_OP
    } op_e;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic [REG_W-1:0]  dest_reg;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

    // Tags 16..63 (including INVALID_NUM) never name a real entry
    function automatic logic tag_in_range(input logic [IDX_W-1:0] tag);
        return tag < IDX_W'(ROB_DEPTH);
    endfunction

endpackage

// File: rtl/rob_buffer_if.sv
// rtl/rob_buffer_if.sv - issue, CDB, lookup and retire signals of the ROB
interface rob_buffer_if;
    import rob_buffer_pkg::*;

    logic              flush;
    logic              alloc_valid;
    logic [REG_W-1:0]  alloc_dest_reg;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_rob_num;
    logic              CDBiscast;
    logic [IDX_W-1:0]  CDBrobNum;
    logic [DATA_W-1:0] CDBdata;
    logic              CDBiscast2;
    logic [IDX_W-1:0]  CDBrobNum2;
    logic [DATA_W-1:0] CDBdata2;
    logic [IDX_W-1:0]  index;
    logic              ready;
    logic [DATA_W-1:0] value;
    logic              commit_valid;
    logic [REG_W-1:0]  commit_reg;
    logic [DATA_W-1:0] commit_data;
    logic [IDX_W-1:0]  commit_rob_num;
    logic [CNT_W-1:0]  count;

    modport master (
        output flush, alloc_valid, alloc_dest_reg,
        output CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2, CDBdata2,
        output index,
        input  alloc_ready, alloc_rob_num, ready, value,
        input  commit_valid, commit_reg, commit_data, commit_rob_num, count
    );

    modport slave (
        input  flush, alloc_valid, alloc_dest_reg,
        input  CDBiscast, CDBrobNum, CDBdata, CDBiscast2, CDBrobNum2, CDBdata2,
        input  index,
        output alloc_ready, alloc_rob_num, ready, value,
        output commit_valid, commit_reg, commit_data, commit_rob_num, count
    );
endinterface

// File: rtl/rob_lookup.sv
// rtl/rob_lookup.sv - operand lookup mux with two-port CDB bypass
module rob_lookup
    import rob_buffer_pkg::*;
(
    input  logic [IDX_W-1:0]  index,
    input  logic [ROB_DEPTH-1:0] entry_done,
    input  logic [DATA_W-1:0] entry_data [ROB_DEPTH],
    input  logic              cdb1_valid,
    input  logic [IDX_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb1_data,
    input  logic              cdb2_valid,
    input  logic [IDX_W-1:0]  cdb2_tag,
    input  logic [DATA_W-1:0] cdb2_data,
    output logic              ready,
    output logic [DATA_W-1:0] value
);

    logic [PTR_W-1:0] slot;
    assign slot = index[PTR_W-1:0];

    // Stored result first, then same-cycle broadcast (port 1 before port 2)
    always_comb begin
        ready = 1'b0;
        value = '0;
        if (tag_in_range(index)) begin
            if (entry_done[slot]) begin
                ready = 1'b1;
                value = entry_data[slot];
            end else if (cdb1_valid && (cdb1_tag == index)) begin
                ready = 1'b1;
                value = cdb1_data;
            end else if (cdb2_valid && (cdb2_tag == index)) begin
                ready = 1'b1;
                value = cdb2_data;
            end
        end
    end

endmodule

// File: rtl/rob_buffer.sv
// rtl/rob_buffer.sv - reorder buffer: tag allocation, CDB capture, in-order retire
module rob_buffer
    import rob_buffer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    rob_buffer_if.slave rif
);

    rob_entry_t        entries_q [ROB_DEPTH];
    rob_entry_t        entries_d [ROB_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              commit_valid_q, commit_valid_d;
    logic [REG_W-1:0]  commit_reg_q, commit_reg_d;
    logic [DATA_W-1:0] commit_data_q, commit_data_d;
    logic [IDX_W-1:0]  commit_rob_num_q, commit_rob_num_d;

    logic              alloc_ready;
    logic              alloc_fire;
    logic              commit_fire;
    logic [ROB_DEPTH-1:0] entry_done;
    logic [DATA_W-1:0] entry_data [ROB_DEPTH];

    // Full check uses the pre-edge count, so a same-edge retire never frees a slot early
    assign alloc_ready = count_q < CNT_W'(ROB_DEPTH);
    assign alloc_fire  = rif.alloc_valid && alloc_ready;
    assign commit_fire = entries_q[head_q].busy && entries_q[head_q].done;

    assign rif.alloc_ready    = alloc_ready;
    assign rif.alloc_rob_num  = {{(IDX_W-PTR_W){1'b0}}, tail_q};
    assign rif.count          = count_q;
    assign rif.commit_valid   = commit_valid_q;
    assign rif.commit_reg     = commit_reg_q;
    assign rif.commit_data    = commit_data_q;
    assign rif.commit_rob_num = commit_rob_num_q;

    // Flatten entry state into the view the lookup mux needs
    always_comb begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
            entry_done[i] = entries_q[i].busy && entries_q[i].done;
            entry_data[i] = entries_q[i].data;
        end
    end

    rob_lookup u_lookup (
        .index      (rif.index),
        .entry_done (entry_done),
        .entry_data (entry_data),
        .cdb1_valid (rif.CDBiscast),
        .cdb1_tag   (rif.CDBrobNum),
        .cdb1_data  (rif.CDBdata),
        .cdb2_valid (rif.CDBiscast2),
        .cdb2_tag   (rif.CDBrobNum2),
        .cdb2_data  (rif.CDBdata2),
        .ready      (rif.ready),
        .value      (rif.value)
    );

    // Next state: flush overrides; otherwise capture, allocate, then retire head
    always_comb begin
        entries_d        = entries_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        commit_valid_d   = 1'b0;
        commit_reg_d     = commit_reg_q;
        commit_data_d    = commit_data_q;
        commit_rob_num_d = commit_rob_num_q;

        if (rif.flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_d[i].busy = 1'b0;
                entries_d[i].done = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Port 2 is applied first so port 1 overwrites it on a shared tag
            if (rif.CDBiscast2 && tag_in_range(rif.CDBrobNum2)
                    && entries_q[rif.CDBrobNum2[PTR_W-1:0]].busy) begin
                entries_d[rif.CDBrobNum2[PTR_W-1:0]].done = 1'b1;
                entries_d[rif.CDBrobNum2[PTR_W-1:0]].data = rif.CDBdata2;
            end
            if (rif.CDBiscast && tag_in_range(rif.CDBrobNum)
                    && entries_q[rif.CDBrobNum[PTR_W-1:0]].busy) begin
                entries_d[rif.CDBrobNum[PTR_W-1:0]].done = 1'b1;
                entries_d[rif.CDBrobNum[PTR_W-1:0]].data = rif.CDBdata;
            end

            if (alloc_fire) begin
                entries_d[tail_q].busy     = 1'b1;
                entries_d[tail_q].done     = 1'b0;
                entries_d[tail_q].dest_reg = rif.alloc_dest_reg;
                tail_d                     = tail_q + 1'b1;
            end

            if (commit_fire) begin
                entries_d[head_q].busy = 1'b0;
                entries_d[head_q].done = 1'b0;
                head_d                 = head_q + 1'b1;
                commit_valid_d         = 1'b1;
                commit_reg_d           = entries_q[head_q].dest_reg;
                commit_data_d          = entries_q[head_q].data;
                commit_rob_num_d       = {{(IDX_W-PTR_W){1'b0}}, head_q};
            end

            count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            commit_valid_q   <= 1'b0;
            commit_reg_q     <= '0;
            commit_data_q    <= '0;
            commit_rob_num_q <= INVALID_NUM;
        end else begin
            entries_q        <= entries_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            commit_valid_q   <= commit_valid_d;
            commit_reg_q     <= commit_reg_d;
            commit_data_q    <= commit_data_d;
            commit_rob_num_q <= commit_rob_num_d;
        end
    end

endmodule

// File: tb/tb_rob_buffer.sv
// tb/tb_rob_buffer.sv - scoreboard bench for rob_buffer
module tb_rob_buffer;
    import rob_buffer_pkg::*;

    logic clock;
    logic reset;
    rob_buffer_if rif ();

    rob_buffer dut (
        .clock (clock),
        .reset (reset),
        .rif   (rif)
    );

    typedef struct {
        logic [REG_W-1:0]  r;
        logic [DATA_W-1:0] d;
        logic [IDX_W-1:0]  t;
    } exp_t;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d, input logic [IDX_W-1:0] t);
        exp_t e;
        e.r = r;
        e.d = d;
        e.t = t;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        rif.flush          = 1'b0;
        rif.alloc_valid    = 1'b0;
        rif.alloc_dest_reg = '0;
        rif.CDBiscast      = 1'b0;
        rif.CDBrobNum      = '0;
        rif.CDBdata        = '0;
        rif.CDBiscast2     = 1'b0;
        rif.CDBrobNum2     = '0;
        rif.CDBdata2       = '0;
        rif.index          = '0;
    endtask

    // Retire monitor: every commit pulse must match the oldest expected retire
    always @(negedge clock) begin
        if (!reset && rif.commit_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_commit: got reg %0d data 0x%0h tag %0d, required no commit",
                         rif.commit_reg, rif.commit_data, rif.commit_rob_num);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("commit_reg", 32'(rif.commit_reg), 32'(e.r));
                check("commit_data", rif.commit_data, e.d);
                check("commit_rob_num", 32'(rif.commit_rob_num), 32'(e.t));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clock);
        #1;
        check("rst_alloc_ready", 32'(rif.alloc_ready), 32'd1);
        check("rst_alloc_rob_num", 32'(rif.alloc_rob_num), 32'd0);
        check("rst_count", 32'(rif.count), 32'd0);
        check("rst_ready", 32'(rif.ready), 32'd0);
        check("rst_value", rif.value, 32'd0);
        check("rst_commit_valid", 32'(rif.commit_valid), 32'd0);
        check("rst_commit_rob_num", 32'(rif.commit_rob_num), 32'd16);
        reset = 1'b0;

        // Two allocations, out-of-order completion, in-order retire
        @(negedge clock);
        rif.alloc_valid = 1'b1; rif.alloc_dest_reg = 5'd3;
        #1 check("t1_tag0", 32'(rif.alloc_rob_num), 32'd0);
        @(negedge clock);
        rif.alloc_dest_reg = 5'd5;
        #1 check("t1_tag1", 32'(rif.alloc_rob_num), 32'd1);
        @(negedge clock);
        rif.alloc_valid = 1'b0;
        #1 check("t1_count2", 32'(rif.count), 32'd2);
        rif.CDBiscast = 1'b1; rif.CDBrobNum = 6'd1; rif.CDBdata = 32'd7;
        @(negedge clock);
        rif.CDBrobNum = 6'd0; rif.CDBdata = 32'd9; rif.index = 6'd1;
        #1;
        check("t1_lookup1_ready", 32'(rif.ready), 32'd1);
        check("t1_lookup1_value", rif.value, 32'd7);
        push(5'd3, 32'd9, 6'd0);
        push(5'd5, 32'd7, 6'd1);
        @(negedge clock);
        rif.CDBiscast = 1'b0;
        repeat (4) @(negedge clock);
        #1 check("t1_count0", 32'(rif.count), 32'd0);

        // Flush returns the pointers to zero
        @(negedge clock); rif.flush = 1'b1;
        @(negedge clock); rif.flush = 1'b0;
        #1;
        check("fl1_count", 32'(rif.count), 32'd0);
        check("fl1_tail", 32'(rif.alloc_rob_num), 32'd0);

        // Fill all 16 slots
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            rif.alloc_valid = 1'b1; rif.alloc_dest_reg = 5'(i + 1);
            #1 check("full_tag", 32'(rif.alloc_rob_num), 32'(i));
        end
        @(negedge clock);
        rif.alloc_dest_reg = 5'd31;
        #1;
        check("full_ready", 32'(rif.alloc_ready), 32'd0);
        check("full_count", 32'(rif.count), 32'd16);
        @(negedge clock);
        rif.alloc_valid = 1'b0;
        #1;
        check("full_17th_count", 32'(rif.count), 32'd16);
        check("full_17th_tail", 32'(rif.alloc_rob_num), 32'd0);
        rif.CDBiscast = 1'b1; rif.CDBrobNum = 6'd0; rif.CDBdata = 32'h100;
        push(5'd1, 32'h100, 6'd0);
        @(negedge clock);
        rif.CDBiscast = 1'b0;
        rif.alloc_valid = 1'b1; rif.alloc_dest_reg = 5'd30;
        #1 check("full_commit_edge_ready", 32'(rif.alloc_ready), 32'd0);
        @(negedge clock);
        rif.alloc_valid = 1'b0;
        #1;
        check("after_commit_count", 32'(rif.count), 32'd15);
        check("after_commit_ready", 32'(rif.alloc_ready), 32'd1);
        check("wrap_tag", 32'(rif.alloc_rob_num), 32'd0);
        rif.alloc_valid = 1'b1; rif.alloc_dest_reg = 5'd20;
        @(negedge clock);
        rif.alloc_valid = 1'b0;
        #1;
        check("refill_count", 32'(rif.count), 32'd16);
        check("refill_ready", 32'(rif.alloc_ready), 32'd0);
        check("refill_tail", 32'(rif.alloc_rob_num), 32'd1);

        // Same-cycle CDB port 2 bypass, invalid index, pending entry
        rif.index = 6'd2;
        rif.CDBiscast2 = 1'b1; rif.CDBrobNum2 = 6'd2; rif.CDBdata2 = 32'hDEAD;
        #1;
        check("byp2_ready", 32'(rif.ready), 32'd1);
        check("byp2_value", rif.value, 32'hDEAD);
        @(negedge clock);
        rif.CDBiscast2 = 1'b0;
        rif.index = INVALID_NUM;
        #1;
        check("inv_ready", 32'(rif.ready), 32'd0);
        check("inv_value", rif.value, 32'd0);
        rif.index = 6'd3;
        #1 check("pending_ready", 32'(rif.ready), 32'd0);
        rif.index = 6'd2;
        #1;
        check("stored2_ready", 32'(rif.ready), 32'd1);
        check("stored2_value", rif.value, 32'hDEAD);

        // Both ports on tag 4: port 1 wins for bypass and capture
        @(negedge clock);
        rif.CDBiscast  = 1'b1; rif.CDBrobNum  = 6'd4; rif.CDBdata  = 32'd11;
        rif.CDBiscast2 = 1'b1; rif.CDBrobNum2 = 6'd4; rif.CDBdata2 = 32'd22;
        rif.index = 6'd4;
        #1;
        check("dual_byp_ready", 32'(rif.ready), 32'd1);
        check("dual_byp_value", rif.value, 32'd11);
        @(negedge clock);
        rif.CDBiscast = 1'b0; rif.CDBiscast2 = 1'b0;
        #1;
        check("dual_stored_ready", 32'(rif.ready), 32'd1);
        check("dual_stored_value", rif.value, 32'd11);

        // Complete head tag 1: retires tags 1 and 2, stops at pending tag 3
        rif.CDBiscast = 1'b1; rif.CDBrobNum = 6'd1; rif.CDBdata = 32'h55;
        push(5'd2, 32'h55, 6'd1);
        push(5'd3, 32'hDEAD, 6'd2);
        @(negedge clock);
        rif.CDBiscast = 1'b0;
        repeat (4) @(negedge clock);
        #1 check("drain_count", 32'(rif.count), 32'd14);

        // Flush with 5 busy entries plus same-edge alloc and CDB
        @(negedge clock); rif.flush = 1'b1;
        @(negedge clock); rif.flush = 1'b0;
        #1 check("fl2_count", 32'(rif.count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            rif.alloc_valid = 1'b1; rif.alloc_dest_reg = 5'(i + 1);
        end
        @(negedge clock);
        rif.alloc_dest_reg = 5'd9; rif.flush = 1'b1;
        rif.CDBiscast = 1'b1; rif.CDBrobNum = 6'd0; rif.CDBdata = 32'd9;
        #1 check("fl3_pre_count", 32'(rif.count), 32'd5);
        @(negedge clock);
        clear_inputs();
        #1;
        check("fl3_count", 32'(rif.count), 32'd0);
        check("fl3_tail", 32'(rif.alloc_rob_num), 32'd0);
        check("fl3_alloc_ready", 32'(rif.alloc_ready), 32'd1);
        check("fl3_commit_valid", 32'(rif.commit_valid), 32'd0);
        check("fl3_lookup0_ready", 32'(rif.ready), 32'd0);
        repeat (3) @(negedge clock);

        // Asynchronous reset while a commit pulse is on the outputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            rif.alloc_valid = 1'b1; rif.alloc_dest_reg = 5'(7 + i);
        end
        @(negedge clock);
        rif.alloc_valid = 1'b0;
        rif.CDBiscast = 1'b1; rif.CDBrobNum = 6'd0; rif.CDBdata = 32'h77;
        push(5'd7, 32'h77, 6'd0);
        @(negedge clock);
        rif.CDBiscast = 1'b0;
        @(negedge clock);
        #1 check("pre_rst_commit_valid", 32'(rif.commit_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_commit_valid", 32'(rif.commit_valid), 32'd0);
        check("arst_commit_reg", 32'(rif.commit_reg), 32'd0);
        check("arst_commit_data", rif.commit_data, 32'd0);
        check("arst_commit_rob_num", 32'(rif.commit_rob_num), 32'd16);
        check("arst_count", 32'(rif.count), 32'd0);
        check("arst_alloc_ready", 32'(rif.alloc_ready), 32'd1);
        check("arst_alloc_rob_num", 32'(rif.alloc_rob_num), 32'd0);
        check("arst_ready", 32'(rif.ready), 32'd0);
        check("arst_value", rif.value, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            if (sb.size() != 0) @(negedge clock);
        end
        repeat (3) @(negedge clock);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
